reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 26 ++
 rtl/reset_sequencer_timer.sv | 29 ++
 rtl/reset_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and width helpers for the staged reset sequencer.
// The sequencer walks HOLD -> RELEASE -> RUN and releases one stage per step.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } seq_state_t;

  // Counter must reach max(hold, gap); never narrower than one bit.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    int w;
    m = (hold > gap) ? hold : gap;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_width(input int stages);
    int w;
    w = $clog2(stages);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// Loadable down-counter that stops at zero and flags it.
// A load takes priority over a decrement on the same edge.
module reset_sequencer_timer #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: holds all stages asserted, then releases them in
// order from bit 0, spaced by a fixed gap. A restart request reruns it.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int   STAGES = 4,
  parameter int   HOLD   = 16,
  parameter int   GAP    = 8,
  parameter logic POL    = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  output logic              restart_ack,
  output logic [STAGES-1:0] rst_out,
  output logic              ready
);

  localparam int CNT_W = cnt_width(HOLD, GAP);
  localparam int IDX_W = idx_width(STAGES);
  localparam logic [STAGES-1:0] ALL_ASSERTED = {STAGES{POL}};

  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic [STAGES-1:0] r_rst_out;
  logic [STAGES-1:0] w_rst_next;
  logic              r_ready;
  logic              w_ready_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_next;
  logic              r_restart_d;
  logic              r_ack;
  logic              w_ack_next;
  logic              w_load;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_dec;
  logic              w_zero;

  reset_sequencer_timer #(
    .W       (CNT_W),
    .RST_VAL (CNT_W'(HOLD))
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rst_next   = r_rst_out;
    w_ready_next = r_ready;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_dec        = 1'b0;
    w_ack_next   = restart & ~r_restart_d;

    if (restart) begin
      // Restart wins in every state; reloading here drops any stale count.
      w_rst_next   = ALL_ASSERTED;
      w_ready_next = 1'b0;
      w_load       = 1'b1;
      w_load_val   = CNT_W'(HOLD);
      w_idx_next   = '0;
      w_state_next = S_HOLD;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (!w_zero) begin
            w_dec = 1'b1;
          end else begin
            w_rst_next[0] = ~POL;
            w_idx_next    = IDX_W'(1);
            w_load        = 1'b1;
            w_load_val    = CNT_W'(GAP);
            if (STAGES == 1) begin
              w_state_next = S_RUN;
              w_ready_next = 1'b1;
            end else begin
              w_state_next = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (!w_zero) begin
            w_dec = 1'b1;
          end else begin
            for (int i = 0; i < STAGES; i++) begin
              if (IDX_W'(i) == r_idx) w_rst_next[i] = ~POL;
            end
            w_idx_next = r_idx + IDX_W'(1);
            w_load     = 1'b1;
            w_load_val = CNT_W'(GAP);
            if (r_idx == IDX_W'(STAGES - 1)) begin
              w_state_next = S_RUN;
              w_ready_next = 1'b1;
            end
          end
        end
        S_RUN: begin
        end
        default: begin
          w_state_next = S_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_out   <= ALL_ASSERTED;
      r_ready     <= 1'b0;
      r_idx       <= '0;
      r_restart_d <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_rst_out   <= w_rst_next;
      r_ready     <= w_ready_next;
      r_idx       <= w_idx_next;
      r_restart_d <= restart;
      r_ack       <= w_ack_next;
    end
  end

  assign rst_out     = r_rst_out;
  assign ready       = r_ready;
  assign restart_ack = r_ack;

endmodule
